// File: rtl/buffer_ctrl.sv
// buffer_ctrl: pointer/occupancy controller for a parallel-write circular Buffer.
//
// It accepts PAR_WRITE-word producer bursts and serves PAR_READ-word consumer reads over
// valid/ready handshakes. It also generates the Buffer's wen/waddr/raddr. Reads are held
// off until START_LVL words are stored (priming). A synchronous flush discards all
// contents in one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous discard of all contents
//   in_valid   producer presents PAR_WRITE words on Buffer.din
//   in_ready   a write can be accepted this cycle
//   out_valid  Buffer.dout holds PAR_READ valid words
//   out_ready  consumer takes the words this cycle
//   buf_wen    Buffer write enable (combinational, same cycle as the handshake)
//   buf_waddr  Buffer write address (write pointer)
//   buf_raddr  Buffer read address (read pointer)
//   count      words currently stored (0..NUMP1)
//   full       count == NUMP1
//   empty      count == 0
//
// Legal only if NUMP1 <= 2**(ADDR_REG+1)-1.
module buffer_ctrl #(
  parameter int unsigned ADDR_REG  = 2,
  parameter int unsigned NUM_REG   = 4,
  parameter int unsigned NUMP1     = 5,
  parameter int unsigned PAR_WRITE = 2,
  parameter int unsigned PAR_READ  = 1,
  parameter int unsigned START_LVL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              buf_wen,
  output logic [ADDR_REG:0] buf_waddr,
  output logic [ADDR_REG:0] buf_raddr,
  output logic [ADDR_REG:0] count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned W = ADDR_REG + 1;

  typedef logic [W-1:0] ptr_t;
  // One extra bit so that count + PAR_WRITE and pointer sums never overflow.
  typedef logic [W:0]   ext_t;

  localparam ext_t DepthC = ext_t'(NUMP1);
  localparam ext_t LastC  = ext_t'(NUM_REG);
  localparam ext_t WrC    = ext_t'(PAR_WRITE);
  localparam ext_t RdC    = ext_t'(PAR_READ);
  localparam ext_t StartC = ext_t'(START_LVL);
  localparam ptr_t DepthN = ptr_t'(NUMP1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun,
    StFlush
  } state_e;

  state_e state_q;
  ptr_t   wptr_q, rptr_q, count_q;

  logic wr, rd;
  ext_t cnt_ext, wr_sum, rd_sum, wptr_nxt, rptr_nxt, cnt_nxt;

  assign cnt_ext = {1'b0, count_q};

  // Based on the current count only; a same-cycle read never frees space for a write,
  // so there is no combinational path from out_ready to in_ready.
  // Gating with rst keeps in_ready and buf_wen low while reset is asserted.
  assign in_ready  = rst && ((DepthC - cnt_ext) >= WrC) && (state_q != StFlush) && !flush;
  assign out_valid = (state_q == StRun) && (cnt_ext >= RdC) && !flush;

  assign wr = in_valid & in_ready;
  assign rd = out_valid & out_ready;

  // Circular wrap by compare-and-subtract. A single subtract suffices because
  // ptr < NUMP1 and the step is <= NUMP1.
  always_comb begin
    wr_sum   = {1'b0, wptr_q} + WrC;
    rd_sum   = {1'b0, rptr_q} + RdC;
    wptr_nxt = (wr_sum > LastC) ? (wr_sum - DepthC) : wr_sum;
    rptr_nxt = (rd_sum > LastC) ? (rd_sum - DepthC) : rd_sum;
    cnt_nxt  = cnt_ext + (wr ? WrC : '0) - (rd ? RdC : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      // wr and rd are already suppressed by flush in in_ready/out_valid.
      state_q <= StFlush;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_nxt[W-1:0];
      if (rd) rptr_q <= rptr_nxt[W-1:0];
      count_q <= cnt_nxt[W-1:0];
      unique case (state_q)
        StIdle: begin
          if (wr) state_q <= (cnt_nxt >= StartC) ? StRun : StFill;
        end
        StFill: begin
          if (cnt_nxt >= StartC) state_q <= StRun;
        end
        StRun: begin
          if (cnt_nxt == '0)      state_q <= StIdle;
          else if (cnt_nxt < RdC) state_q <= StFill;
        end
        StFlush: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign buf_wen   = wr;
  assign buf_waddr = wptr_q;
  assign buf_raddr = rptr_q;
  assign count     = count_q;
  assign full      = (count_q == DepthN);
  assign empty     = (count_q == '0);

endmodule

// File: tb/tb_buffer_ctrl.sv
// Bench for buffer_ctrl with default parameters (NUMP1=5, PAR_WRITE=2, PAR_READ=1,
// START_LVL=3). Each write pushes the buffer addresses it fills into a queue, and each
// accepted read pops the next expected read address.
module tb_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, out_ready;
  logic       in_ready, out_valid, buf_wen, full, empty;
  logic [2:0] buf_waddr, buf_raddr, count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: m_st 0=idle 1=fill 2=run 3=flush.
  int m_cnt, m_wp, m_rp, m_st;
  int exp_q[$];

  always #5 clk = ~clk;

  buffer_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .buf_wen   (buf_wen),
    .buf_waddr (buf_waddr),
    .buf_raddr (buf_raddr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_wp  = 0;
    m_rp  = 0;
    m_st  = 0;
    exp_q.delete();
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs before the rising edge,
  // advance the model, and return at the next falling edge.
  task automatic step(input logic iv, input logic ordy, input logic fl);
    logic e_ir, e_ov, e_wr, e_rd;
    int   nc;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    #2;
    e_ir = ((5 - m_cnt) >= 2) && (m_st != 3) && !fl;
    e_ov = (m_st == 2) && (m_cnt >= 1) && !fl;
    e_wr = iv && e_ir;
    e_rd = e_ov && ordy;
    chk("in_ready",  in_ready,  e_ir);
    chk("out_valid", out_valid, e_ov);
    chk("buf_wen",   buf_wen,   e_wr);
    chk("buf_waddr", buf_waddr, m_wp);
    chk("buf_raddr", buf_raddr, m_rp);
    chk("count",     count,     m_cnt);
    chk("full",      full,      m_cnt == 5);
    chk("empty",     empty,     m_cnt == 0);
    if (e_wr) begin
      for (int k = 0; k < 2; k++) exp_q.push_back((m_wp + k) % 5);
    end
    if (e_rd) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_raddr", buf_raddr, exp_q.pop_front());
    end
    nc = m_cnt + (e_wr ? 2 : 0) - (e_rd ? 1 : 0);
    if (fl) begin
      m_st = 3; m_cnt = 0; m_wp = 0; m_rp = 0;
      exp_q.delete();
    end else begin
      if (e_wr) m_wp = (m_wp + 2) % 5;
      if (e_rd) m_rp = (m_rp + 1) % 5;
      m_cnt = nc;
      case (m_st)
        0: if (e_wr) m_st = (nc >= 3) ? 2 : 1;
        1: if (nc >= 3) m_st = 2;
        2: if (nc == 0) m_st = 0; else if (nc < 1) m_st = 1;
        default: m_st = 0;
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with in_valid high: nothing may leak through.
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #3;
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_buf_wen",   buf_wen,   0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count",     count,     0);
    chk("rst_empty",     empty,     1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();

    // Fill: waddr 0,2; count 2 then 4; third cycle blocked.
    step(1, 0, 0);
    chk("dir_fill_cnt2", count, 2);
    step(1, 0, 0);
    chk("dir_fill_cnt4", count, 4);
    step(1, 0, 0);
    chk("dir_blocked_wptr", buf_waddr, 4);

    // Reads raddr 0,1,2.
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("dir_read_cnt1", count, 1);

    // Wrap: write at 4 -> wptr 1, then reads 3,4,0.
    step(1, 0, 0);
    chk("dir_wrap_wptr", buf_waddr, 1);
    chk("dir_wrap_cnt",  count, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("dir_wrap_rptr", buf_raddr, 1);
    chk("dir_drained",   count, 0);

    // Simultaneous write and read at count 3 in RUN.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("dir_wrrd_cnt",  count, 4);
    chk("dir_wrrd_wptr", buf_waddr, 2);
    chk("dir_wrrd_rptr", buf_raddr, 3);

    // Flush with both handshakes requested.
    step(1, 1, 1);
    step(1, 1, 0);
    chk("dir_flush_cnt", count, 0);
    step(0, 0, 0);

    // Fill to full, stall a read, then drain.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("dir_full",     full, 1);
    chk("dir_full_cnt", count, 5);
    step(1, 0, 0);
    chk("dir_stall_rptr", buf_raddr, 1);
    chk("dir_stall_cnt",  count, 5);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    chk("dir_full_drain", empty, 1);

    // Random traffic with occasional flush.
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

    // Reset asserted mid-cycle while in RUN with both handshakes active.
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    in_valid = 1'b1; out_ready = 1'b1;
    #2;
    chk("pre_rst_wen", buf_wen,   1);
    chk("pre_rst_ov",  out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_wen",   buf_wen,   0);
    chk("mid_rst_ov",    out_valid, 0);
    chk("mid_rst_cnt",   count,     0);
    chk("mid_rst_ir",    in_ready,  0);
    chk("mid_rst_waddr", buf_waddr, 0);
    chk("mid_rst_raddr", buf_raddr, 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    step(1, 0, 0);
    chk("post_rst_cnt", count, 2);
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
